divu_hilo_ctrl: RTL

//  Sequencer for the multi-cycle unsigned divider and owner of the HI/LO register pair.

---
 rtl/divu_hilo_ctrl_pkg.sv | 42 ++++
 rtl/divu_hilo_ctrl_core.sv | 53 +++++
 rtl/divu_hilo_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/divu_hilo_ctrl_pkg.sv
// Shared decode constants, FSM states and HI/LO instruction decode
// for the divide sequencer.
package divu_hilo_ctrl_pkg;

    localparam logic [5:0]  R_FORMAT  = 6'd0;
    localparam logic [5:0]  FN_MFHI   = 6'd16;
    localparam logic [5:0]  FN_MTHI   = 6'd17;
    localparam logic [5:0]  FN_MFLO   = 6'd18;
    localparam logic [5:0]  FN_MTLO   = 6'd19;
    localparam logic [5:0]  FN_DIVU   = 6'd27;
    localparam logic [31:0] INSTR_NOP = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic divu;
        logic mfhi;
        logic mthi;
        logic mflo;
        logic mtlo;
    } hilo_dec_t;

    function automatic hilo_dec_t hilo_decode(
        input logic [31:0] instr,
        input logic        valid
    );
        hilo_dec_t d;
        logic      live;
        live   = valid && (instr != INSTR_NOP)
                 && (instr[31:26] == R_FORMAT);
        d.divu = live && (instr[5:0] == FN_DIVU);
        d.mfhi = live && (instr[5:0] == FN_MFHI);
        d.mthi = live && (instr[5:0] == FN_MTHI);
        d.mflo = live && (instr[5:0] == FN_MFLO);
        d.mtlo = live && (instr[5:0] == FN_MTLO);
        return d;
    endfunction

endpackage

// File: rtl/divu_hilo_ctrl_core.sv
// Restoring unsigned divider datapath: one quotient bit per step.
// Outputs are the values produced by the step taken this cycle.
module divu_hilo_ctrl_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_div;

    logic [DATA_W:0]   w_shift;
    logic [DATA_W-1:0] w_diff;
    logic              w_ge;
    logic [DATA_W-1:0] w_quo_nx;
    logic [DATA_W-1:0] w_rem_nx;

    // Bring in the next dividend bit; the compare is one bit wider
    // than the operands, so the low bits of the difference suffice.
    assign w_shift  = {r_rem, r_quo[DATA_W-1]};
    assign w_ge     = (w_shift >= {1'b0, r_div});
    assign w_diff   = w_shift[DATA_W-1:0] - r_div;
    assign w_quo_nx = {r_quo[DATA_W-2:0], w_ge};
    assign w_rem_nx = w_ge ? w_diff : w_shift[DATA_W-1:0];

    assign quotient  = w_quo_nx;
    assign remainder = w_rem_nx;

    // Load operands on start, otherwise advance one step when asked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (start) begin
            r_quo <= dividend;
            r_rem <= '0;
            r_div <= divisor;
        end else if (step) begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
        end
    end

endmodule

// File: rtl/divu_hilo_ctrl.sv
// Divide sequencer and HI/LO owner: stalls only HI/LO users while
// a divide runs; everything else issues freely.
module divu_hilo_ctrl
    import divu_hilo_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    state_t            r_state;
    state_t            w_state_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    hilo_dec_t         w_dec;
    logic              w_hilo;
    logic              w_start;
    logic              w_step;
    logic              w_last;
    logic [DATA_W-1:0] w_quo;
    logic [DATA_W-1:0] w_rem;

    // Instructions are ignored while reset is held.
    assign w_dec  = hilo_decode(instr, instr_valid & ~rst);
    assign w_hilo = |w_dec;
    assign stall  = r_busy & w_hilo;
    assign busy   = r_busy;
    assign done   = r_done;

    divu_hilo_ctrl_core #(
        .DATA_W (DATA_W)
    ) u_divu_core (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .step      (w_step),
        .dividend  (rs_data),
        .divisor   (rt_data),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Next state: accept divu when idle, finish when the count expires.
    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_step     = 1'b0;
        w_last     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_dec.divu) begin
                    w_start    = 1'b1;
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_last     = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Step counter plus busy flag and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_start) begin
                r_cnt  <= CNT_W'(DATA_W);
                r_busy <= 1'b1;
            end else if (w_step) begin
                r_cnt  <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    // HI/LO take the divide result, or moves while no divide runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
        end else if (!stall) begin
            if (w_dec.mthi) begin
                r_hi <= rs_data;
            end
            if (w_dec.mtlo) begin
                r_lo <= rs_data;
            end
        end
    end

    // Read port for mfhi/mflo; a stalled read returns nothing.
    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        if (!stall) begin
            if (w_dec.mfhi) begin
                rd_data  = r_hi;
                rd_valid = 1'b1;
            end else if (w_dec.mflo) begin
                rd_data  = r_lo;
                rd_valid = 1'b1;
            end
        end
    end

endmodule
